// File: rtl/unified_mem_arbiter_if.sv
// ---------------------------------------------------------------------------
// unified_mem_arbiter_if
//   Bundles every bus signal of the unified memory arbiter: the IF-stage
//   fetch port, the MEM-stage data port, the memory port, and the pipeline
//   stall/busy indications.
//
//   modport master : environment side (pipeline requesters plus memory).
//                    It drives requests and mem_rdata and observes the rest.
//   modport slave  : arbiter side.
//
//   Signals
//     if_req/if_addr[63:0]          fetch request and byte address
//     if_rvalid/if_rdata[31:0]      fetch response pulse and instruction word
//     dm_req/dm_we/dm_addr/dm_wdata data request, store flag, address, store data
//     dm_rvalid/dm_rdata[63:0]      data response pulse and load data
//     mem_req/mem_we/mem_addr/mem_wdata  memory strobe and command
//     mem_rdata[63:0]               memory read data (fixed latency)
//     stall_if/stall_mem/busy       pipeline freeze controls, access in flight
// ---------------------------------------------------------------------------
interface unified_mem_arbiter_if;
  logic        if_req;
  logic [63:0] if_addr;
  logic        if_rvalid;
  logic [31:0] if_rdata;

  logic        dm_req;
  logic        dm_we;
  logic [63:0] dm_addr;
  logic [63:0] dm_wdata;
  logic        dm_rvalid;
  logic [63:0] dm_rdata;

  logic        mem_req;
  logic        mem_we;
  logic [63:0] mem_addr;
  logic [63:0] mem_wdata;
  logic [63:0] mem_rdata;

  logic        stall_if;
  logic        stall_mem;
  logic        busy;

  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
    input  if_rvalid, if_rdata, dm_rvalid, dm_rdata,
    input  mem_req, mem_we, mem_addr, mem_wdata,
    input  stall_if, stall_mem, busy
  );

  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
    output if_rvalid, if_rdata, dm_rvalid, dm_rdata,
    output mem_req, mem_we, mem_addr, mem_wdata,
    output stall_if, stall_mem, busy
  );
endinterface

// File: rtl/unified_mem_arbiter.sv
// ---------------------------------------------------------------------------
// unified_mem_arbiter
//   Shares one single-ported, fixed-latency memory between the IF stage and
//   the MEM stage of the pipeline. One access is outstanding at a time; the
//   response is routed back to its owner and per-stage stalls are generated.
//
//   Parameters
//     MEM_LAT    cycles from mem_req to valid mem_rdata (1..15)
//     STARVE_MAX consecutive IF losses before IF gets priority (1..15)
//
//   Ports
//     clk    core clock, rising edge
//     reset  asynchronous, active-low reset
//     bus    unified_mem_arbiter_if.slave (requesters, memory, stalls, busy)
//     if_stall_cnt[31:0], dm_stall_cnt[31:0]  stall cycle counters, only
//            present when ARB_PERF_CNT_EN is defined
//
//   Build option
//     ARB_PERF_CNT_EN  adds the two free-running stall cycle counters.
// ---------------------------------------------------------------------------
module unified_mem_arbiter #(
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  unified_mem_arbiter_if.slave bus
`ifdef ARB_PERF_CNT_EN
  ,
  output logic [31:0]          if_stall_cnt,
  output logic [31:0]          dm_stall_cnt
`endif
);

  localparam logic [3:0] LAT_C    = 4'(MEM_LAT);
  localparam logic [3:0] STARVE_C = 4'(STARVE_MAX);

  typedef enum logic [1:0] {IDLE, ACC_IF, ACC_DM} state_t;

  state_t     state_q, state_d;
  logic [3:0] lat_cnt_q, lat_cnt_d;
  logic [3:0] starve_cnt_q, starve_cnt_d;

  logic issue_if, issue_dm;
  logic done_if, done_dm;
  logic if_rvalid_w, dm_rvalid_w;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      lat_cnt_q    <= 4'd0;
      starve_cnt_q <= 4'd0;
    end else begin
      state_q      <= state_d;
      lat_cnt_q    <= lat_cnt_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    lat_cnt_d    = lat_cnt_q;
    starve_cnt_d = starve_cnt_q;
    issue_if     = 1'b0;
    issue_dm     = 1'b0;
    done_if      = 1'b0;
    done_dm      = 1'b0;
    case (state_q)
      IDLE: begin
        // DM normally wins so the older instruction drains; IF takes over
        // once it has lost STARVE_MAX times in a row.
        if (bus.dm_req && ((starve_cnt_q < STARVE_C) || !bus.if_req)) begin
          issue_dm  = 1'b1;
          state_d   = ACC_DM;
          lat_cnt_d = 4'd1;
          if (bus.if_req && (starve_cnt_q != 4'hF)) begin
            starve_cnt_d = starve_cnt_q + 4'd1;
          end
        end else if (bus.if_req) begin
          issue_if     = 1'b1;
          state_d      = ACC_IF;
          lat_cnt_d    = 4'd1;
          starve_cnt_d = 4'd0;
        end
      end
      ACC_IF, ACC_DM: begin
        // lat_cnt reaches MEM_LAT exactly when the memory data is valid.
        if (lat_cnt_q == LAT_C) begin
          done_if   = (state_q == ACC_IF);
          done_dm   = (state_q == ACC_DM);
          state_d   = IDLE;
          lat_cnt_d = 4'd0;
        end else begin
          lat_cnt_d = lat_cnt_q + 4'd1;
        end
      end
      default: begin
        state_d   = IDLE;
        lat_cnt_d = 4'd0;
      end
    endcase
  end

  // While reset is held every control output is forced low, even though the
  // combinational issue path would otherwise see a pending request in IDLE.
  assign if_rvalid_w   = done_if & reset;
  assign dm_rvalid_w   = done_dm & reset;

  assign bus.mem_req   = (issue_if | issue_dm) & reset;
  assign bus.mem_we    = issue_dm & bus.dm_we & reset;
  assign bus.mem_addr  = issue_dm ? bus.dm_addr : (issue_if ? bus.if_addr : 64'd0);
  assign bus.mem_wdata = issue_dm ? bus.dm_wdata : 64'd0;

  assign bus.if_rvalid = if_rvalid_w;
  assign bus.dm_rvalid = dm_rvalid_w;
  assign bus.if_rdata  = bus.mem_rdata[31:0];
  assign bus.dm_rdata  = bus.mem_rdata;

  assign bus.busy      = (state_q != IDLE);
  assign bus.stall_if  = bus.if_req & ~if_rvalid_w & reset;
  assign bus.stall_mem = bus.dm_req & ~dm_rvalid_w & reset;

`ifdef ARB_PERF_CNT_EN
  logic [31:0] if_stall_cnt_q, if_stall_cnt_d;
  logic [31:0] dm_stall_cnt_q, dm_stall_cnt_d;

  always_comb begin
    if_stall_cnt_d = if_stall_cnt_q + {31'd0, bus.stall_if};
    dm_stall_cnt_d = dm_stall_cnt_q + {31'd0, bus.stall_mem};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      if_stall_cnt_q <= 32'd0;
      dm_stall_cnt_q <= 32'd0;
    end else begin
      if_stall_cnt_q <= if_stall_cnt_d;
      dm_stall_cnt_q <= dm_stall_cnt_d;
    end
  end

  assign if_stall_cnt = if_stall_cnt_q;
  assign dm_stall_cnt = dm_stall_cnt_q;
`endif

endmodule

// File: tb/tb_unified_mem_arbiter.sv
module tb_unified_mem_arbiter;
  localparam int MEM_LAT    = 2;
  localparam int STARVE_MAX = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  unified_mem_arbiter_if bus ();

`ifdef ARB_PERF_CNT_EN
  logic [31:0] if_stall_cnt, dm_stall_cnt;
`endif

  unified_mem_arbiter #(.MEM_LAT(MEM_LAT), .STARVE_MAX(STARVE_MAX)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef ARB_PERF_CNT_EN
    ,
    .if_stall_cnt (if_stall_cnt),
    .dm_stall_cnt (dm_stall_cnt)
`endif
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Memory content as seen by reads.
  function automatic logic [63:0] memfunc(input logic [63:0] a);
    if (a == 64'h200) return 64'hDEADBEEF_00000001;
    return {a[31:0] ^ 32'hA5A5_A5A5, ~a[31:0]};
  endfunction

  // Fixed-latency memory model: data for a strobe appears MEM_LAT cycles later.
  logic [63:0] pipe [MEM_LAT];
  always @(posedge clk) begin
    pipe[0] <= bus.mem_req ? memfunc(bus.mem_addr) : 64'hBADBADBA_DBADBAD0;
    for (int i = 1; i < MEM_LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign bus.mem_rdata = pipe[MEM_LAT-1];

  // Scoreboard: expectations queued when a request is driven, popped on rvalid.
  typedef struct {
    logic        chk;
    logic [63:0] data;
  } exp_t;
  exp_t if_q[$];
  exp_t dm_q[$];
  exp_t mon_if_e, mon_dm_e;

  always @(negedge clk) begin
    if (bus.if_rvalid) begin
      if (if_q.size() == 0) begin
        check("if_rvalid_unexpected", {63'd0, bus.if_rvalid}, 64'd0);
      end else begin
        mon_if_e = if_q.pop_front();
        check("if_rdata", {32'd0, bus.if_rdata}, {32'd0, mon_if_e.data[31:0]});
        $display("[%0t] IF  response rdata=%h", $time, bus.if_rdata);
      end
    end
    if (bus.dm_rvalid) begin
      if (dm_q.size() == 0) begin
        check("dm_rvalid_unexpected", {63'd0, bus.dm_rvalid}, 64'd0);
      end else begin
        mon_dm_e = dm_q.pop_front();
        if (mon_dm_e.chk) check("dm_rdata", bus.dm_rdata, mon_dm_e.data);
        $display("[%0t] DM  response rdata=%h", $time, bus.dm_rdata);
      end
    end
  end

  // kind: 0 = fetch, 1 = load, 2 = store
  typedef struct {
    logic [1:0]  kind;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic        exp_we;
    logic [63:0] exp_data;
  } tvec_t;
  tvec_t vecs [6];

  task automatic do_single(input tvec_t v);
    int   cyc;
    logic rv;
    @(posedge clk); #1;
    if (v.kind == 2'd0) begin
      bus.if_req  = 1'b1;
      bus.if_addr = v.addr;
      if_q.push_back('{chk: 1'b1, data: v.exp_data});
    end else begin
      bus.dm_req   = 1'b1;
      bus.dm_we    = (v.kind == 2'd2);
      bus.dm_addr  = v.addr;
      bus.dm_wdata = v.wdata;
      dm_q.push_back('{chk: (v.kind != 2'd2), data: v.exp_data});
    end
    @(negedge clk);
    check("issue_mem_req", {63'd0, bus.mem_req}, 64'd1);
    check("issue_mem_addr", bus.mem_addr, v.addr);
    check("issue_mem_we", {63'd0, bus.mem_we}, {63'd0, v.exp_we});
    if (v.kind == 2'd2) check("issue_mem_wdata", bus.mem_wdata, v.wdata);
    check("issue_stall", {63'd0, (v.kind == 2'd0) ? bus.stall_if : bus.stall_mem}, 64'd1);
    check("issue_busy", {63'd0, bus.busy}, 64'd0);
    for (cyc = 1; cyc <= 20; cyc++) begin
      @(negedge clk);
      rv = (v.kind == 2'd0) ? bus.if_rvalid : bus.dm_rvalid;
      if (rv) break;
      check("wait_stall", {63'd0, (v.kind == 2'd0) ? bus.stall_if : bus.stall_mem}, 64'd1);
      check("wait_mem_req", {63'd0, bus.mem_req}, 64'd0);
    end
    check("rvalid_latency", 64'(cyc), 64'(MEM_LAT));
    check("rvalid_stall", {63'd0, (v.kind == 2'd0) ? bus.stall_if : bus.stall_mem}, 64'd0);
    check("rvalid_busy", {63'd0, bus.busy}, 64'd1);
    @(posedge clk); #1;
    bus.if_req = 1'b0;
    bus.dm_req = 1'b0;
    @(negedge clk);
    check("after_busy", {63'd0, bus.busy}, 64'd0);
    check("after_mem_req", {63'd0, bus.mem_req}, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  localparam logic [63:0] A_IF = 64'h4000;
  localparam logic [63:0] B_DM = 64'h8000;

  initial begin
    logic exp_any, exp_if;

    vecs[0] = '{kind: 2'd0, addr: 64'h10,  wdata: 64'd0,  exp_we: 1'b0, exp_data: memfunc(64'h10)};
    vecs[1] = '{kind: 2'd1, addr: 64'h200, wdata: 64'd0,  exp_we: 1'b0, exp_data: 64'hDEADBEEF_00000001};
    vecs[2] = '{kind: 2'd2, addr: 64'h300, wdata: 64'h55, exp_we: 1'b1, exp_data: 64'd0};
    vecs[3] = '{kind: 2'd0, addr: 64'h1002, wdata: 64'd0, exp_we: 1'b0, exp_data: memfunc(64'h1002)};
    vecs[4] = '{kind: 2'd1, addr: 64'hFFFF_FFFF_FFFF_FFF8, wdata: 64'd0, exp_we: 1'b0,
                exp_data: memfunc(64'hFFFF_FFFF_FFFF_FFF8)};
    vecs[5] = '{kind: 2'd2, addr: 64'h8, wdata: 64'hCAFEF00D_12345678, exp_we: 1'b1, exp_data: 64'd0};

    // Reset with requests pending: every control output must be low.
    reset        = 1'b0;
    bus.if_req   = 1'b1;
    bus.if_addr  = 64'h10;
    bus.dm_req   = 1'b1;
    bus.dm_we    = 1'b1;
    bus.dm_addr  = 64'h20;
    bus.dm_wdata = 64'h1;
    #2;
    check("rst_mem_req", {63'd0, bus.mem_req}, 64'd0);
    check("rst_mem_we", {63'd0, bus.mem_we}, 64'd0);
    check("rst_busy", {63'd0, bus.busy}, 64'd0);
    check("rst_stall_if", {63'd0, bus.stall_if}, 64'd0);
    check("rst_stall_mem", {63'd0, bus.stall_mem}, 64'd0);
    check("rst_if_rvalid", {63'd0, bus.if_rvalid}, 64'd0);
    check("rst_dm_rvalid", {63'd0, bus.dm_rvalid}, 64'd0);
    bus.if_req = 1'b0;
    bus.dm_req = 1'b0;
    bus.dm_we  = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;

    for (int i = 0; i < 6; i++) begin
      do_single(vecs[i]);
`ifdef ARB_PERF_CNT_EN
      if (i == 1) begin
        check("perf_if_stall_cnt", {32'd0, if_stall_cnt}, 64'd2);
        check("perf_dm_stall_cnt", {32'd0, dm_stall_cnt}, 64'd2);
      end
`endif
    end

    // Contention with both requests held: DM wins STARVE_MAX times, then IF.
    @(posedge clk); #1;
    bus.if_req  = 1'b1;
    bus.if_addr = A_IF;
    bus.dm_req  = 1'b1;
    bus.dm_we   = 1'b0;
    bus.dm_addr = B_DM;
    for (int k = 0; k < 5; k++) dm_q.push_back('{chk: 1'b1, data: memfunc(B_DM)});
    if_q.push_back('{chk: 1'b1, data: memfunc(A_IF)});
    for (int c = 0; c <= 17; c++) begin
      @(negedge clk);
      exp_if  = (c == 12);
      exp_any = exp_if || (c == 0) || (c == 3) || (c == 6) || (c == 9) || (c == 15);
      check($sformatf("cont_mem_req_c%0d", c), {63'd0, bus.mem_req}, {63'd0, exp_any});
      if (exp_any) check($sformatf("cont_mem_addr_c%0d", c), bus.mem_addr, exp_if ? A_IF : B_DM);
      if (c == 12) check("cont_stall_mem_during_if", {63'd0, bus.stall_mem}, 64'd1);
      if (c == 13) check("cont_starve_cnt_cleared", {60'd0, dut.starve_cnt_q}, 64'd0);
      if (c == 14) begin
        check("cont_if_rvalid", {63'd0, bus.if_rvalid}, 64'd1);
        @(posedge clk); #1;
        bus.if_req = 1'b0;
      end
      if (c == 15) begin
        // Drop dm_req mid-access: the access must still complete.
        @(posedge clk); #1;
        bus.dm_req = 1'b0;
      end
      if (c == 17) check("cont_dropped_req_rvalid", {63'd0, bus.dm_rvalid}, 64'd1);
    end

    // Reset in the middle of a fetch: no response, outputs low at once.
    @(posedge clk); #1;
    bus.if_req  = 1'b1;
    bus.if_addr = 64'h40;
    @(negedge clk);
    check("rstmid_issue", {63'd0, bus.mem_req}, 64'd1);
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    check("rstmid_busy", {63'd0, bus.busy}, 64'd0);
    check("rstmid_mem_req", {63'd0, bus.mem_req}, 64'd0);
    check("rstmid_stall_if", {63'd0, bus.stall_if}, 64'd0);
    bus.if_req = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("rstmid_no_if_rvalid", {63'd0, bus.if_rvalid}, 64'd0);
    end
    do_single('{kind: 2'd0, addr: 64'h80, wdata: 64'd0, exp_we: 1'b0, exp_data: memfunc(64'h80)});

    repeat (3) @(negedge clk);
    check("if_q_drained", 64'(if_q.size()), 64'd0);
    check("dm_q_drained", 64'(dm_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
